// File: rtl/shift_seq.sv
// Multi-cycle barrel shifter/rotator: a large shift amount is split into passes
// of at most 2^SHAMT-1 positions through one small barrel stage per cycle.
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

module shift_seq #(
  parameter int DATA   = 8,
  parameter int SHAMT  = 3,
  parameter int TOTAL  = 6,
  parameter bit ROTATE = `ENABLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATA-1:0]  in_data,
  input  logic [TOTAL-1:0] in_amt,
  input  logic             in_right,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA-1:0]  out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int PMAX = (1 << SHAMT) - 1;
  localparam logic [TOTAL-1:0] PMAX_T = TOTAL'(PMAX);

  state_t           r_state;
  state_t           w_next;
  logic [DATA-1:0]  r_data;
  logic [TOTAL-1:0] r_remaining;
  logic             r_right;
  logic [SHAMT-1:0] w_step;
  logic [TOTAL-1:0] w_remainingNext;
  logic [DATA-1:0]  w_shifted;
  int               w_rotAmt;
  logic             w_accept;

  assign w_accept        = (r_state == IDLE) && in_valid && !flush;
  assign w_step          = (r_remaining > PMAX_T) ? SHAMT'(PMAX) : r_remaining[SHAMT-1:0];
  assign w_remainingNext = r_remaining - TOTAL'(w_step);

  // Rotation amounts are reduced modulo DATA so the stage also works when PMAX >= DATA.
  always_comb begin
    w_rotAmt  = int'(w_step) % DATA;
    w_shifted = r_data;
    if (ROTATE) begin
      if (r_right)
        w_shifted = (r_data >> w_rotAmt) | (r_data << (DATA - w_rotAmt));
      else
        w_shifted = (r_data << w_rotAmt) | (r_data >> (DATA - w_rotAmt));
    end else begin
      if (r_right)
        w_shifted = r_data >> w_step;
      else
        w_shifted = r_data << w_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (in_amt != '0) ? RUN : DONE;
      RUN: begin
        if (flush)
          w_next = IDLE;
        else if (w_remainingNext == '0)
          w_next = DONE;
      end
      DONE: if (flush || out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A flushed pass is not applied; the result is being thrown away anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_remaining <= '0;
      r_right     <= 1'b0;
    end else if (w_accept) begin
      r_data      <= in_data;
      r_remaining <= in_amt;
      r_right     <= in_right;
    end else if (r_state == RUN && !flush) begin
      r_data      <= w_shifted;
      r_remaining <= w_remainingNext;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_data;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: one rotating and one shifting instance driven
// in lockstep, each with its own expected-result queue and monitor.
module tb_shift_seq;

  typedef struct {
    logic [7:0] data;
    int         cycle;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [5:0] amt;
    logic       right;
    logic [7:0] expRot;
    logic [7:0] expShf;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, inValid, inRight, flush, outReady;
  logic [7:0] inData;
  logic [5:0] inAmt;
  logic       inReadyRot, outValidRot, busyRot;
  logic       inReadyShf, outValidShf, busyShf;
  logic [7:0] outDataRot, outDataShf;

  int   cycleCount = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t rotQ[$];
  exp_t shfQ[$];
  vec_t vecs[10];

  logic       rotSeen = 1'b0, shfSeen = 1'b0;
  logic [7:0] rotHeld, shfHeld;

  shift_seq #(.DATA(8), .SHAMT(3), .TOTAL(6), .ROTATE(1'b1)) dutRot (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyRot),
    .in_data(inData), .in_amt(inAmt), .in_right(inRight), .flush(flush),
    .out_valid(outValidRot), .out_ready(outReady), .out_data(outDataRot), .busy(busyRot)
  );

  shift_seq #(.DATA(8), .SHAMT(3), .TOTAL(6), .ROTATE(1'b0)) dutShf (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyShf),
    .in_data(inData), .in_amt(inAmt), .in_right(inRight), .flush(flush),
    .out_valid(outValidShf), .out_ready(outReady), .out_data(outDataShf), .busy(busyShf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cycleCount);
    end
  endtask

  // Monitors pop on the first cycle of each out_valid window, then check the result holds.
  always @(negedge clk) begin
    if (outValidRot) begin
      if (!rotSeen) begin
        if (rotQ.size() == 0) begin
          checkOutput("rot unexpected out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = rotQ.pop_front();
          checkOutput("rot out_data", 32'(outDataRot), 32'(e.data));
          checkOutput("rot latency", 32'(cycleCount), 32'(e.cycle));
        end
        rotHeld = outDataRot;
        rotSeen = 1'b1;
      end else begin
        checkOutput("rot hold stable", 32'(outDataRot), 32'(rotHeld));
      end
    end else begin
      rotSeen = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (outValidShf) begin
      if (!shfSeen) begin
        if (shfQ.size() == 0) begin
          checkOutput("shf unexpected out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = shfQ.pop_front();
          checkOutput("shf out_data", 32'(outDataShf), 32'(e.data));
          checkOutput("shf latency", 32'(cycleCount), 32'(e.cycle));
        end
        shfHeld = outDataShf;
        shfSeen = 1'b1;
      end else begin
        checkOutput("shf hold stable", 32'(outDataShf), 32'(shfHeld));
      end
    end else begin
      shfSeen = 1'b0;
    end
  end

  task automatic applyStimulus(input vec_t v, input int hold);
    int waited;
    @(negedge clk);
    checkOutput("in_ready before accept", 32'(inReadyRot & inReadyShf), 32'd1);
    inValid  = 1'b1;
    inData   = v.data;
    inAmt    = v.amt;
    inRight  = v.right;
    outReady = (hold == 0);
    rotQ.push_back('{data: v.expRot, cycle: cycleCount + v.lat});
    shfQ.push_back('{data: v.expShf, cycle: cycleCount + v.lat});
    @(negedge clk);
    inValid = 1'b0;
    if (hold > 0) begin
      waited = 0;
      while (!outValidRot && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("wait for out_valid", 32'(outValidRot), 32'd1);
      repeat (hold) begin
        checkOutput("held in_ready", 32'(inReadyRot), 32'd0);
        checkOutput("held out_valid", 32'(outValidRot), 32'd1);
        @(negedge clk);
      end
      outReady = 1'b1;
      @(negedge clk);
      checkOutput("release in_ready", 32'(inReadyRot), 32'd1);
      checkOutput("release out_valid", 32'(outValidRot), 32'd0);
    end else begin
      waited = 0;
      while (!(inReadyRot && inReadyShf) && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("return to idle", 32'(inReadyRot & inReadyShf), 32'd1);
    end
  endtask

  task automatic abortTest(input bit useReset);
    @(negedge clk);
    checkOutput("abort in_ready", 32'(inReadyRot), 32'd1);
    inValid  = 1'b1;
    inData   = 8'b10011100;
    inAmt    = 6'd17;
    inRight  = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("abort busy in run", 32'(busyRot & busyShf), 32'd1);
    @(negedge clk);
    if (useReset) reset = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    checkOutput("abort busy", 32'(busyRot | busyShf), 32'd0);
    checkOutput("abort in_ready", 32'(inReadyRot & inReadyShf), 32'd1);
    if (useReset) checkOutput("abort reset out_data", 32'(outDataRot), 32'd0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("no out_valid after abort", 32'(outValidRot | outValidShf), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'b10011100, 6'd0,  1'b0, 8'h9C, 8'h9C, 1};
    vecs[1] = '{8'b10011100, 6'd3,  1'b0, 8'hE4, 8'hE0, 2};
    vecs[2] = '{8'b10011100, 6'd17, 1'b0, 8'h39, 8'h00, 4};
    vecs[3] = '{8'b10011100, 6'd10, 1'b1, 8'h27, 8'h00, 3};
    vecs[4] = '{8'b10011100, 6'd2,  1'b1, 8'h27, 8'h27, 2};
    vecs[5] = '{8'h81,       6'd7,  1'b0, 8'hC0, 8'h80, 2};
    vecs[6] = '{8'hA5,       6'd63, 1'b1, 8'h4B, 8'h00, 10};
    vecs[7] = '{8'h3C,       6'd8,  1'b0, 8'h3C, 8'h00, 3};
    vecs[8] = '{8'hF0,       6'd14, 1'b1, 8'hC3, 8'h00, 3};
    vecs[9] = '{8'hF0,       6'd5,  1'b1, 8'h87, 8'h07, 2};

    reset = 1'b1; inValid = 1'b0; inRight = 1'b0; flush = 1'b0; outReady = 1'b1;
    inData = '0; inAmt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset in_ready", 32'(inReadyRot & inReadyShf), 32'd1);
    checkOutput("reset out_valid", 32'(outValidRot | outValidShf), 32'd0);
    checkOutput("reset busy", 32'(busyRot | busyShf), 32'd0);
    checkOutput("reset out_data", 32'({outDataRot, outDataShf}), 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i], 0);

    // Back-pressure: result must hold while out_ready stays low.
    applyStimulus(vecs[1], 5);
    applyStimulus(vecs[0], 5);

    abortTest(1'b1);
    abortTest(1'b0);

    // Flush in IDLE blocks the request presented in the same cycle.
    @(negedge clk);
    inValid = 1'b1; inAmt = 6'd3; flush = 1'b1;
    @(negedge clk);
    inValid = 1'b0; flush = 1'b0;
    checkOutput("flush in idle blocks accept", 32'(busyRot | busyShf), 32'd0);

    applyStimulus(vecs[2], 0);
    repeat (4) @(negedge clk);
    checkOutput("rot queue drained", 32'(rotQ.size()), 32'd0);
    checkOutput("shf queue drained", 32'(shfQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
